// File: rtl/wb_hazard_ctrl_pkg.sv
// Shared widths, forwarding-select encodings and helpers for the pipeline
// register-file write side.
package wb_hazard_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_MEM  = 2'b01,
      FWD_WB   = 2'b10
   } fwd_sel_e;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   // A load sitting in MEM has no data yet, so it never supplies a forward.
   function automatic fwd_sel_e fwd_select(
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] mem_rd,
      input logic              mem_regwr,
      input logic              mem_load,
      input logic [REG_AW-1:0] wb_rd,
      input logic              wb_regwr
   );
      fwd_sel_e sel;
      sel = FWD_NONE;
      if (mem_regwr && !mem_load && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
         sel = FWD_MEM;
      end else if (wb_regwr && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/wb_hazard_ctrl_if.sv
// Bundle of decode, datapath, hazard and register-file write signals; the
// slave side is the hazard/writeback controller.
interface wb_hazard_ctrl_if;
   import wb_hazard_ctrl_pkg::*;

   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwr;
   logic              id_load;
   logic              flush;
   logic [DATA_W-1:0] ex_alu_result;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall;
   fwd_sel_e          fwd_a;
   fwd_sel_e          fwd_b;
   logic [DATA_W-1:0] mem_fwd_data;
   logic [DATA_W-1:0] wb_fwd_data;
   logic [REG_AW-1:0] rf_rw;
   logic [DATA_W-1:0] rf_busw;
   logic              rf_regwr;

   modport master (
      output id_rs, id_rt, id_rd, id_regwr, id_load, flush, ex_alu_result, mem_rdata,
      input  stall, fwd_a, fwd_b, mem_fwd_data, wb_fwd_data, rf_rw, rf_busw, rf_regwr
   );

   modport slave (
      input  id_rs, id_rt, id_rd, id_regwr, id_load, flush, ex_alu_result, mem_rdata,
      output stall, fwd_a, fwd_b, mem_fwd_data, wb_fwd_data, rf_rw, rf_busw, rf_regwr
   );

endinterface

// File: rtl/wb_hazard_ctrl_hazard_detect.sv
// Purely combinational load-use stall and EX operand forwarding selects.
module wb_hazard_ctrl_hazard_detect
   import wb_hazard_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwr,
   input  logic              ex_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwr,
   input  logic              mem_load,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwr,
   output logic              stall,
   output fwd_sel_e          fwd_a,
   output fwd_sel_e          fwd_b
);

   // One stall cycle is enough: next cycle the load is in MEM and WB-forward covers it.
   always_comb begin
      stall = ex_load && ex_regwr && (ex_rd != REG_ZERO) &&
              ((ex_rd == id_rs) || (ex_rd == id_rt));
      fwd_a = fwd_select(ex_rs, mem_rd, mem_regwr, mem_load, wb_rd, wb_regwr);
      fwd_b = fwd_select(ex_rt, mem_rd, mem_regwr, mem_load, wb_rd, wb_regwr);
   end

endmodule

// File: rtl/wb_hazard_ctrl.sv
// EX/MEM/WB stage registers for destination control and result data, driving
// the register-file write port and the hazard unit.
module wb_hazard_ctrl
   import wb_hazard_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   wb_hazard_ctrl_if.slave bus
);

   logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
   logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic              ex_regwr_q, ex_regwr_d;
   logic              ex_load_q, ex_load_d;
   logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
   logic              mem_regwr_q, mem_regwr_d;
   logic              mem_load_q, mem_load_d;
   logic [DATA_W-1:0] mem_alu_q, mem_alu_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic              wb_regwr_q, wb_regwr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic              stall;
   logic              bubble;

   // Stall and flush collapse into the same single bubble in EX.
   always_comb begin
      bubble      = stall || bus.flush;
      ex_rs_d     = bus.id_rs;
      ex_rt_d     = bus.id_rt;
      ex_rd_d     = bubble ? REG_ZERO : bus.id_rd;
      ex_regwr_d  = bubble ? 1'b0 : bus.id_regwr;
      ex_load_d   = bubble ? 1'b0 : bus.id_load;
      mem_rd_d    = ex_rd_q;
      mem_regwr_d = ex_regwr_q;
      mem_load_d  = ex_load_q;
      mem_alu_d   = bus.ex_alu_result;
      wb_rd_d     = mem_rd_q;
      wb_regwr_d  = mem_regwr_q;
      wb_data_d   = mem_load_q ? bus.mem_rdata : mem_alu_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         ex_regwr_q  <= 1'b0;
         ex_load_q   <= 1'b0;
         mem_rd_q    <= '0;
         mem_regwr_q <= 1'b0;
         mem_load_q  <= 1'b0;
         mem_alu_q   <= '0;
         wb_rd_q     <= '0;
         wb_regwr_q  <= 1'b0;
         wb_data_q   <= '0;
      end else begin
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_rd_q     <= ex_rd_d;
         ex_regwr_q  <= ex_regwr_d;
         ex_load_q   <= ex_load_d;
         mem_rd_q    <= mem_rd_d;
         mem_regwr_q <= mem_regwr_d;
         mem_load_q  <= mem_load_d;
         mem_alu_q   <= mem_alu_d;
         wb_rd_q     <= wb_rd_d;
         wb_regwr_q  <= wb_regwr_d;
         wb_data_q   <= wb_data_d;
      end
   end

   wb_hazard_ctrl_hazard_detect u_hazard_detect (
      .id_rs     (bus.id_rs),
      .id_rt     (bus.id_rt),
      .ex_rs     (ex_rs_q),
      .ex_rt     (ex_rt_q),
      .ex_rd     (ex_rd_q),
      .ex_regwr  (ex_regwr_q),
      .ex_load   (ex_load_q),
      .mem_rd    (mem_rd_q),
      .mem_regwr (mem_regwr_q),
      .mem_load  (mem_load_q),
      .wb_rd     (wb_rd_q),
      .wb_regwr  (wb_regwr_q),
      .stall     (stall),
      .fwd_a     (bus.fwd_a),
      .fwd_b     (bus.fwd_b)
   );

   // Writes to r0 are suppressed here so the register file never sees them.
   assign bus.stall        = stall;
   assign bus.mem_fwd_data = mem_alu_q;
   assign bus.wb_fwd_data  = wb_data_q;
   assign bus.rf_rw        = wb_rd_q;
   assign bus.rf_busw      = wb_data_q;
   assign bus.rf_regwr     = wb_regwr_q && (wb_rd_q != REG_ZERO);

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// Directed, table-driven bench for wb_hazard_ctrl plus hand-written sequences
// for the stall/flush overlap and mid-stream reset.
module tb_wb_hazard_ctrl;
   import wb_hazard_ctrl_pkg::*;

   typedef struct {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        regwr;
      logic        load;
      logic        flush;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        exp_stall;
      logic [1:0]  exp_fwd_a;
      logic [1:0]  exp_fwd_b;
      logic        exp_regwr;
      logic [4:0]  exp_rw;
      logic [31:0] exp_busw;
      logic [31:0] exp_mem_fwd;
   } vec_t;

   localparam int NVEC = 14;

   logic clk;
   logic reset;
   int   total_checks;
   int   passed_checks;
   vec_t vecs [NVEC];

   wb_hazard_ctrl_if bus ();

   wb_hazard_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act === exp) begin
         passed_checks++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.id_rs         = v.rs;
      bus.id_rt         = v.rt;
      bus.id_rd         = v.rd;
      bus.id_regwr      = v.regwr;
      bus.id_load       = v.load;
      bus.flush         = v.flush;
      bus.ex_alu_result = v.alu;
      bus.mem_rdata     = v.rdata;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic regwr, input logic load, input logic flush,
                        input logic [31:0] alu, input logic [31:0] rdata);
      vec_t v;
      v = '{rs, rt, rd, regwr, load, flush, alu, rdata, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0};
      applyStimulus(v);
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;

      // Pipeline walk: add->use, load-use, double write, r0 writes, flush.
      //           rs  rt  rd  wr ld fl  alu            rdata          st fa  fb  wr rw   busw           memfwd
      vecs[0]  = '{1,  2,  3,  1, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0,  32'h0,         32'h0};
      vecs[1]  = '{3,  4,  6,  1, 0, 0, 32'hAA,        32'h0,         0, 0, 0, 0, 0,  32'h0,         32'h0};
      vecs[2]  = '{8,  0,  5,  1, 1, 0, 32'h11,        32'h0,         0, 1, 0, 0, 0,  32'h0,         32'hAA};
      vecs[3]  = '{9,  5,  10, 1, 0, 0, 32'h100,       32'h0,         1, 0, 0, 1, 3,  32'hAA,        32'h11};
      vecs[4]  = '{9,  5,  10, 1, 0, 0, 32'h0,         32'hDEADBEEF,  0, 0, 0, 1, 6,  32'h11,        32'h100};
      vecs[5]  = '{1,  2,  7,  1, 0, 0, 32'h22,        32'h0,         0, 0, 2, 1, 5,  32'hDEADBEEF,  32'h0};
      vecs[6]  = '{1,  2,  7,  1, 0, 0, 32'h1,         32'h0,         0, 0, 0, 0, 0,  32'h0,         32'h22};
      vecs[7]  = '{7,  0,  11, 1, 0, 0, 32'h2,         32'h0,         0, 0, 0, 1, 10, 32'h22,        32'h1};
      vecs[8]  = '{0,  0,  0,  1, 1, 0, 32'h33,        32'h0,         0, 1, 0, 1, 7,  32'h1,         32'h2};
      vecs[9]  = '{0,  0,  12, 1, 0, 0, 32'h44,        32'h55,        0, 0, 0, 1, 7,  32'h2,         32'h33};
      vecs[10] = '{1,  2,  9,  1, 0, 1, 32'h66,        32'h77,        0, 0, 0, 1, 11, 32'h33,        32'h44};
      vecs[11] = '{0,  0,  0,  0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0,  32'h77,        32'h66};
      vecs[12] = '{0,  0,  0,  0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 1, 12, 32'h66,        32'h0};
      vecs[13] = '{0,  0,  0,  0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0,  32'h0,         32'h0};

      // Reset state
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset.stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("reset.fwd_a", {30'd0, bus.fwd_a}, 32'd0);
      checkOutput("reset.fwd_b", {30'd0, bus.fwd_b}, 32'd0);
      checkOutput("reset.rf_regwr", {31'd0, bus.rf_regwr}, 32'd0);
      checkOutput("reset.rf_busw", bus.rf_busw, 32'd0);
      reset = 1'b0;

      // Table walk: drive at negedge, sample 2 time units later
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #2;
         checkOutput($sformatf("v%0d.stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].exp_stall});
         checkOutput($sformatf("v%0d.fwd_a", i), {30'd0, bus.fwd_a}, {30'd0, vecs[i].exp_fwd_a});
         checkOutput($sformatf("v%0d.fwd_b", i), {30'd0, bus.fwd_b}, {30'd0, vecs[i].exp_fwd_b});
         checkOutput($sformatf("v%0d.rf_regwr", i), {31'd0, bus.rf_regwr}, {31'd0, vecs[i].exp_regwr});
         checkOutput($sformatf("v%0d.rf_rw", i), {27'd0, bus.rf_rw}, {27'd0, vecs[i].exp_rw});
         checkOutput($sformatf("v%0d.rf_busw", i), bus.rf_busw, vecs[i].exp_busw);
         checkOutput($sformatf("v%0d.wb_fwd", i), bus.wb_fwd_data, vecs[i].exp_busw);
         checkOutput($sformatf("v%0d.mem_fwd", i), bus.mem_fwd_data, vecs[i].exp_mem_fwd);
      end

      // Stall and flush together: one bubble, the held consumer still executes
      @(negedge clk); drive(8, 0, 5, 1, 1, 0, 32'h0, 32'h0);
      @(negedge clk); drive(5, 0, 13, 1, 0, 1, 32'h200, 32'h0);
      #2 checkOutput("sf.stall_on", {31'd0, bus.stall}, 32'd1);
      @(negedge clk); drive(5, 0, 13, 1, 0, 0, 32'h0, 32'h12345678);
      #2 checkOutput("sf.stall_off", {31'd0, bus.stall}, 32'd0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 32'hAB, 32'h0);
      #2;
      checkOutput("sf.fwd_a_wb", {30'd0, bus.fwd_a}, 32'd2);
      checkOutput("sf.load_rw", {27'd0, bus.rf_rw}, 32'd5);
      checkOutput("sf.load_data", bus.rf_busw, 32'h12345678);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      #2;
      checkOutput("sf.consumer_regwr", {31'd0, bus.rf_regwr}, 32'd1);
      checkOutput("sf.consumer_rw", {27'd0, bus.rf_rw}, 32'd13);
      checkOutput("sf.consumer_busw", bus.rf_busw, 32'hAB);

      // Mid-stream reset with a write pending in WB and a load-use stall live
      @(negedge clk); drive(0, 0, 14, 1, 0, 0, 32'h5, 32'h0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk); drive(14, 0, 15, 1, 1, 0, 32'h0, 32'h0);
      @(negedge clk); drive(15, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      #2;
      checkOutput("rst.pre_regwr", {31'd0, bus.rf_regwr}, 32'd1);
      checkOutput("rst.pre_rw", {27'd0, bus.rf_rw}, 32'd14);
      checkOutput("rst.pre_stall", {31'd0, bus.stall}, 32'd1);
      checkOutput("rst.pre_fwd_a", {30'd0, bus.fwd_a}, 32'd2);
      reset = 1'b1;
      #1;
      checkOutput("rst.regwr", {31'd0, bus.rf_regwr}, 32'd0);
      checkOutput("rst.stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("rst.fwd_a", {30'd0, bus.fwd_a}, 32'd0);
      checkOutput("rst.fwd_b", {30'd0, bus.fwd_b}, 32'd0);
      checkOutput("rst.mem_fwd", bus.mem_fwd_data, 32'd0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      reset = 1'b0;
      #2 checkOutput("rst.after_deassert", {31'd0, bus.rf_regwr}, 32'd0);
      @(negedge clk);
      #2 checkOutput("rst.next_cycle", {31'd0, bus.rf_regwr}, 32'd0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
